// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter and baud controller between N_REQ byte requesters.
// The winner's byte and baud code are latched, then the Tx_EN/Tx_WR/Tx_BUSY handshake is run to completion.
module uart_tx_scheduler #(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [3*N_REQ-1:0]   req_baud,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic                 err,
    output logic                 busy,
    output logic                 Tx_EN,
    output logic                 Tx_WR,
    output logic [7:0]           Tx_DATA,
    output logic [2:0]           baud_select,
    input  logic                 Tx_BUSY,
    output logic [2:0]           state_dbg
);
    localparam int LW = $clog2(N_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [LW-1:0] LAST_RST = LW'(N_REQ - 1);
    localparam logic [LW:0]   NREQ_W   = (LW + 1)'(N_REQ);
    localparam logic [CW-1:0] TIMEOUT  = CW'(BUSY_TIMEOUT);

    typedef enum logic [2:0] {IDLE, SETUP, WRITE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [7:0]        data_q, data_d;
    logic [2:0]        baud_q, baud_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              err_q, err_d;
    logic              en_q, en_d;
    logic              wr_q, wr_d;

    // Arbiter: first pending requester searching upward from last+1 with wrap.
    logic              found;
    logic [LW-1:0]     sel;
    logic [LW:0]       sum;
    logic [7:0]        sel_data;
    logic [2:0]        sel_baud;

    always_comb begin
        found    = 1'b0;
        sel      = last_q;
        sum      = '0;
        sel_data = 8'h00;
        sel_baud = 3'b000;
        for (int off = 1; off <= N_REQ; off++) begin
            sum = {1'b0, last_q} + (LW + 1)'(off);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            if (!found && req[sum[LW-1:0]]) begin
                found    = 1'b1;
                sel      = sum[LW-1:0];
                sel_data = req_data[{sum[LW-1:0], 3'b000} +: 8];
                sel_baud = req_baud[(LW + 2)'(sum[LW-1:0]) * (LW + 2)'(3) +: 3];
            end
        end
    end

    // Transmitter handshake: Tx_WR is a single-cycle strobe issued with Tx_EN already high;
    // the transmitter acknowledges by raising Tx_BUSY and signals frame completion by dropping it.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        baud_d  = baud_q;
        grant_d = '0;
        done_d  = '0;
        err_d   = 1'b0;
        wr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found && !Tx_BUSY) begin
                    state_d      = SETUP;
                    last_d       = sel;
                    data_d       = sel_data;
                    baud_d       = sel_baud;
                    grant_d[sel] = 1'b1;
                end
            end
            SETUP: begin
                state_d = WRITE;
                wr_d    = 1'b1;
            end
            WRITE: begin
                state_d = WAIT_BUSY;
                cnt_d   = '0;
            end
            WAIT_BUSY: begin
                if (Tx_BUSY) begin
                    state_d = WAIT_DONE;
                end else begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cnt_d == TIMEOUT) begin
                        state_d        = IDLE;
                        done_d[last_q] = 1'b1;
                        err_d          = 1'b1;
                    end
                end
            end
            WAIT_DONE: begin
                if (!Tx_BUSY) begin
                    state_d        = IDLE;
                    done_d[last_q] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        en_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            data_q  <= '0;
            baud_q  <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            baud_q  <= baud_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            en_q    <= en_d;
            wr_q    <= wr_d;
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign err         = err_q;
    assign Tx_EN       = en_q;
    assign Tx_WR       = wr_q;
    assign Tx_DATA     = data_q;
    assign baud_select = baud_q;
    assign busy        = (state_q != IDLE);
    assign state_dbg   = state_q;
endmodule
